uart_mmio: RTL and testbench

UART peripheral that consumes the memory controller's UART MMIO strobes (byte window 0xaaaaa400–0xaaaaa407) and drives the board serial pins. It contains:
- a 16-entry TX FIFO feeding an 8N1 serializer;
- a 16x-oversampling deserializer feeding a 16-entry RX FIFO;
- a programmable baud divisor.

Read data is combinational, so the memory controller can register it on the same edge as the access strobe.

---
 rtl/uart_mmio.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART with 16-entry TX/RX FIFOs, an 8N1 serializer,
// a 16x-oversampling deserializer and a programmable baud divisor.
// Optional feature macro: UART_LOOPBACK_EN (CTRL bit0 routes tx back into rx).
module uart_mmio #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [15:0] DIV_RESET  = 16'd53
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       tx_wen,
    input  logic       rx_ren,
    input  logic [2:0] uart_addr,
    input  logic [7:0] uart_din,
    output logic [7:0] uart_dout,
    output logic       tx_full,
    output logic       rx_data_present,
    output logic       tx,
    input  logic       rx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // Access decode; a write wins if both strobes ever assert together.
    logic wr_data, wr_div_lo, wr_div_hi, rd_data, rd_status;
    assign wr_data   = tx_wen && (uart_addr == 3'd0);
    assign wr_div_lo = tx_wen && (uart_addr == 3'd2);
    assign wr_div_hi = tx_wen && (uart_addr == 3'd3);
    assign rd_data   = rx_ren && !tx_wen && (uart_addr == 3'd0);
    assign rd_status = rx_ren && !tx_wen && (uart_addr == 3'd1);

    // ---------------- baud divisor and tick generator ----------------
    logic [15:0] div_q, div_d, cnt_q, cnt_d;
    logic        tick;
    assign tick = (cnt_q == div_q);

    // Divisor writes and tick counter next state; any divisor write restarts the count.
    always_comb begin
        div_d = div_q;
        if (wr_div_lo) div_d[7:0]  = uart_din;
        if (wr_div_hi) div_d[15:8] = uart_din;
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;
        if (wr_div_lo || wr_div_hi) cnt_d = 16'd0;
    end

    // Divisor and tick counter registers.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            div_q <= DIV_RESET;
            cnt_q <= 16'd0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          tx_push, tx_pop, tx_empty;
    assign tx_full  = (tx_cnt_q == FULL_CNT);
    assign tx_empty = (tx_cnt_q == '0);
    assign tx_push  = wr_data && !tx_full;

    // TX occupancy next state.
    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
        else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
    end

    // TX storage write port.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr_q] <= uart_din;
    end

    // TX pointers and count.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            tx_wr_q  <= '0;
            tx_rd_q  <= '0;
            tx_cnt_q <= '0;
        end else begin
            if (tx_push) tx_wr_q <= tx_wr_q + AW'(1);
            if (tx_pop)  tx_rd_q <= tx_rd_q + AW'(1);
            tx_cnt_q <= tx_cnt_d;
        end
    end

    // ---------------- TX serializer ----------------
    state_t     tx_state_q, tx_state_d;
    logic [7:0] tx_shift_q;
    logic [3:0] tx_tick_q;
    logic [2:0] tx_bit_q;
    logic       tx_line, tx_idle;

    // TX state register.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) tx_state_q <= S_IDLE;
        else      tx_state_q <= tx_state_d;
    end

    // TX next state: 16 ticks per bit, 8 data bits between start and stop.
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            S_IDLE:  if (!tx_empty) tx_state_d = S_START;
            S_START: if (tick && tx_tick_q == 4'd15) tx_state_d = S_DATA;
            S_DATA:  if (tick && tx_tick_q == 4'd15 && tx_bit_q == 3'd7) tx_state_d = S_STOP;
            S_STOP:  if (tick && tx_tick_q == 4'd15) tx_state_d = S_IDLE;
            default: tx_state_d = S_IDLE;
        endcase
    end

    // TX outputs: line level and FIFO pop.
    always_comb begin
        tx_line = 1'b1;
        tx_pop  = 1'b0;
        case (tx_state_q)
            S_IDLE:  tx_pop  = !tx_empty;
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_shift_q[0];
            default: tx_line = 1'b1;
        endcase
    end

    // TX datapath: load on pop, count ticks, shift LSB first.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            tx_shift_q <= 8'h00;
            tx_tick_q  <= 4'd0;
            tx_bit_q   <= 3'd0;
        end else if (tx_state_q == S_IDLE) begin
            tx_tick_q <= 4'd0;
            tx_bit_q  <= 3'd0;
            if (!tx_empty) tx_shift_q <= tx_mem[tx_rd_q];
        end else if (tick) begin
            tx_tick_q <= tx_tick_q + 4'd1;
            if (tx_state_q == S_DATA && tx_tick_q == 4'd15) begin
                tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                tx_bit_q   <= tx_bit_q + 3'd1;
            end
        end
    end

    assign tx_idle = tx_empty && (tx_state_q == S_IDLE);

    // ---------------- loopback option ----------------
    logic       rx_src;
    logic [7:0] ctrl_rd;
`ifdef UART_LOOPBACK_EN
    logic loop_q;

    // CTRL loopback bit.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst)                               loop_q <= 1'b0;
        else if (tx_wen && uart_addr == 3'd4)   loop_q <= uart_din[0];
    end

    assign rx_src  = loop_q ? tx_line : rx;
    assign tx      = loop_q ? 1'b1 : tx_line;
    assign ctrl_rd = {7'b0, loop_q};
`else
    assign rx_src  = rx;
    assign tx      = tx_line;
    assign ctrl_rd = 8'h00;
`endif

    // ---------------- RX deserializer ----------------
    logic [1:0] sync_q;
    logic       rx_prev_q, rx_s;
    state_t     rx_state_q, rx_state_d;
    logic [7:0] rx_shift_q;
    logic [3:0] rx_tick_q;
    logic [2:0] rx_bit_q;
    logic       rx_push, rx_ferr;
    assign rx_s = sync_q[1];

    // Two-flop synchronizer plus previous-sample register for edge detection.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx_src};
            rx_prev_q <= rx_s;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) rx_state_q <= S_IDLE;
        else      rx_state_q <= rx_state_d;
    end

    // RX next state: mid-start check after 8 ticks, then one sample every 16.
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            S_IDLE:  if (rx_prev_q && !rx_s) rx_state_d = S_START;
            S_START: if (tick && rx_tick_q == 4'd7) rx_state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:  if (tick && rx_tick_q == 4'd15 && rx_bit_q == 3'd7) rx_state_d = S_STOP;
            S_STOP:  if (tick && rx_tick_q == 4'd15) rx_state_d = S_IDLE;
            default: rx_state_d = S_IDLE;
        endcase
    end

    // RX outputs: push on a good stop bit, frame error on a bad one.
    always_comb begin
        rx_push = 1'b0;
        rx_ferr = 1'b0;
        if (rx_state_q == S_STOP && tick && rx_tick_q == 4'd15) begin
            rx_push = rx_s;
            rx_ferr = !rx_s;
        end
    end

    // RX datapath: tick counting and LSB-first shift.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            rx_shift_q <= 8'h00;
            rx_tick_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
        end else begin
            case (rx_state_q)
                S_IDLE: begin
                    rx_tick_q <= 4'd0;
                    rx_bit_q  <= 3'd0;
                end
                S_START: if (tick) rx_tick_q <= (rx_tick_q == 4'd7) ? 4'd0 : rx_tick_q + 4'd1;
                S_DATA: if (tick) begin
                    rx_tick_q <= rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_shift_q <= {rx_s, rx_shift_q[7:1]};
                        rx_bit_q   <= rx_bit_q + 3'd1;
                    end
                end
                default: if (tick) rx_tick_q <= rx_tick_q + 4'd1;
            endcase
        end
    end

    // ---------------- RX FIFO and sticky flags ----------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_q, rx_rd_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic          rx_full, rx_pop, rx_acc;
    logic          ovr_q, ovr_d, ferr_q, ferr_d;
    assign rx_full         = (rx_cnt_q == FULL_CNT);
    assign rx_data_present = (rx_cnt_q != '0);
    assign rx_pop          = rd_data && rx_data_present;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign rx_acc          = rx_push && (!rx_full || rx_pop);

    // RX occupancy and sticky flag next state; new events beat a status-read clear.
    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_acc && !rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
        else if (!rx_acc && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);
        ovr_d  = rd_status ? 1'b0 : ovr_q;
        ferr_d = rd_status ? 1'b0 : ferr_q;
        if (rx_push && !rx_acc) ovr_d  = 1'b1;
        if (rx_ferr)            ferr_d = 1'b1;
    end

    // RX storage write port.
    always_ff @(posedge clk) begin
        if (rx_acc) rx_mem[rx_wr_q] <= rx_shift_q;
    end

    // RX pointers, count and sticky flags.
    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            ovr_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            if (rx_acc) rx_wr_q <= rx_wr_q + AW'(1);
            if (rx_pop) rx_rd_q <= rx_rd_q + AW'(1);
            rx_cnt_q <= rx_cnt_d;
            ovr_q    <= ovr_d;
            ferr_q   <= ferr_d;
        end
    end

    // Combinational read mux so the access strobe cycle sees the data.
    always_comb begin
        uart_dout = 8'h00;
        case (uart_addr)
            3'd0:    if (rx_data_present) uart_dout = rx_mem[rx_rd_q];
            3'd1:    uart_dout = {3'b000, ferr_q, ovr_q, tx_idle, tx_full, rx_data_present};
            3'd2:    uart_dout = div_q[7:0];
            3'd3:    uart_dout = div_q[15:8];
            3'd4:    uart_dout = ctrl_rd;
            default: uart_dout = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio: register map, TX framing and full FIFO,
// RX reception, false start, frame error, overrun, optional loopback.
module tb_uart_mmio;
    logic       clk = 1'b0;
    logic       Rst = 1'b0;
    logic       tx_wen = 1'b0;
    logic       rx_ren = 1'b0;
    logic [2:0] uart_addr = 3'd0;
    logic [7:0] uart_din = 8'h00;
    logic [7:0] uart_dout;
    logic       tx_full, rx_data_present, tx;
    logic       rx = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] tx_exp[$];
    logic [7:0] tx_got[$];
    logic [7:0] rx_exp[$];

    uart_mmio dut (
        .clk(clk), .Rst(Rst), .tx_wen(tx_wen), .rx_ren(rx_ren),
        .uart_addr(uart_addr), .uart_din(uart_din), .uart_dout(uart_dout),
        .tx_full(tx_full), .rx_data_present(rx_data_present), .tx(tx), .rx(rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic mmio_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        tx_wen = 1'b1; uart_addr = a; uart_din = d;
        @(negedge clk);
        tx_wen = 1'b0;
        $display("write addr=%0d data=%02h", a, d);
    endtask

    task automatic mmio_read(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        rx_ren = 1'b1; uart_addr = a;
        #1 d = uart_dout;
        @(negedge clk);
        rx_ren = 1'b0;
        $display("read  addr=%0d data=%02h", a, d);
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        uart_addr = a;
        #1 d = uart_dout;
        $display("peek  addr=%0d data=%02h", a, d);
    endtask

    // One 8N1 frame at 16 clocks per bit (divisor 0).
    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0; repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i]; repeat (16) @(negedge clk);
        end
        rx = stop; repeat (16) @(negedge clk);
        rx = 1'b1; repeat (6) @(negedge clk);
        $display("rx frame %02h stop=%0d", b, stop);
    endtask

    // Scoreboard model of the RX FIFO: keeps the first 16 unread bytes.
    task automatic model_rx(input logic [7:0] b);
        if (rx_exp.size() < 16) rx_exp.push_back(b);
    endtask

    task automatic read_rx_check(input string tag);
        logic [7:0] d, e;
        e = 8'h00;
        if (rx_exp.size() != 0) e = rx_exp.pop_front();
        mmio_read(3'd0, d);
        check(tag, d, e);
    endtask

    // Line monitor for divisor 0: decodes frames into tx_got.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (Rst && tx === 1'b0) begin
                repeat (7) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = tx;
                end
                repeat (16) @(negedge clk);
                if (tx === 1'b1) tx_got.push_back(b);
                $display("tx monitor frame %02h", b);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [7:0] fr;
        int lows;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_full", tx_full, 0);
        check("rst_rx_dp", rx_data_present, 0);
        Rst = 1'b1;
        @(negedge clk);
        peek(3'd0, d); check("rst_data", d, 8'h00);
        peek(3'd1, d); check("rst_status", d, 8'h04);
        peek(3'd2, d); check("rst_div_lo", d, 8'h35);
        peek(3'd3, d); check("rst_div_hi", d, 8'h00);
        peek(3'd4, d); check("rst_ctrl", d, 8'h00);

        // Divisor read/write, then divisor 0 for all serial tests
        mmio_write(3'd2, 8'h12);
        mmio_write(3'd3, 8'h34);
        peek(3'd2, d); check("div_lo_rw", d, 8'h12);
        peek(3'd3, d); check("div_hi_rw", d, 8'h34);
        mmio_write(3'd3, 8'h00);
        mmio_write(3'd2, 8'h00);
        mmio_write(3'd5, 8'hFF);
        peek(3'd5, d); check("addr5_ignored", d, 8'h00);
`ifndef UART_LOOPBACK_EN
        mmio_write(3'd4, 8'h01);
        peek(3'd4, d); check("ctrl_no_loop", d, 8'h00);
`endif

        // Single frame 0xA5, checked bit by bit at mid-bit
        tx_exp.push_back(8'hA5);
        mmio_write(3'd0, 8'hA5);
        check("tx_before_start", tx, 1);
        repeat (8) @(negedge clk);
        fr = 8'hA5;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      check("tx_start_bit", tx, 0);
            else if (k == 9) check("tx_stop_bit", tx, 1);
            else             check($sformatf("tx_data_bit%0d", k - 1), tx, fr[k-1]);
            if (k < 9) repeat (16) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        peek(3'd1, d); check("tx_busy_at_160", d, 8'h00);
        @(negedge clk);
        peek(3'd1, d); check("tx_idle_at_161", d, 8'h04);

        // Full TX FIFO behind a busy serializer: 17th write is dropped
        tx_exp.push_back(8'h11);
        mmio_write(3'd0, 8'h11);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_exp.push_back(8'h20 + 8'(i));
            mmio_write(3'd0, 8'h20 + 8'(i));
            if (i == 14) check("tx_not_full_15", tx_full, 0);
            if (i == 15) check("tx_full_16", tx_full, 1);
            if (i == 16) begin
                check("tx_full_17", tx_full, 1);
                peek(3'd1, d); check("status_full", d, 8'h02);
            end
        end
        repeat (17 * 160 + 400) @(negedge clk);
        check("tx_frame_count", tx_got.size(), tx_exp.size());
        while (tx_exp.size() != 0 && tx_got.size() != 0)
            check("tx_frame_byte", tx_got.pop_front(), tx_exp.pop_front());
        peek(3'd1, d); check("tx_drained", d, 8'h04);

        // RX single frame and pop
        model_rx(8'h3C);
        send_rx(8'h3C, 1'b1);
        check("rx_dp_set", rx_data_present, 1);
        read_rx_check("rx_3c");
        check("rx_dp_clear", rx_data_present, 0);
        mmio_read(3'd0, d); check("rx_empty_read", d, 8'h00);

        // One-clock glitch is a false start
        @(negedge clk); rx = 1'b0;
        @(negedge clk); rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_byte", rx_data_present, 0);

        // Frame error (TX idle, so tx_idle bit stays set)
        send_rx(8'h55, 1'b0);
        check("ferr_no_push", rx_data_present, 0);
        mmio_read(3'd1, d); check("ferr_status", d, 8'h14);
        mmio_read(3'd1, d); check("ferr_cleared", d, 8'h04);

        // Overrun: 17 frames with no reads
        for (int i = 0; i < 17; i++) begin
            model_rx(8'h40 + 8'(i));
            send_rx(8'h40 + 8'(i), 1'b1);
        end
        peek(3'd1, d); check("ovr_status", d, 8'h0D);
        mmio_read(3'd1, d); check("ovr_status_rd", d, 8'h0D);
        peek(3'd1, d); check("ovr_cleared", d, 8'h05);
        for (int i = 0; i < 16; i++) read_rx_check("ovr_fifo_byte");
        check("ovr_drained", rx_data_present, 0);
        peek(3'd1, d); check("ovr_final_status", d, 8'h04);

`ifdef UART_LOOPBACK_EN
        mmio_write(3'd4, 8'h01);
        peek(3'd4, d); check("ctrl_loop", d, 8'h01);
        model_rx(8'h5A);
        mmio_write(3'd0, 8'h5A);
        lows = 0;
        for (int i = 0; i < 220; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("loop_pin_high", lows, 0);
        check("loop_rx_dp", rx_data_present, 1);
        read_rx_check("loop_byte");
        mmio_write(3'd4, 8'h00);
`else
        lows = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
